pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised pipeline-stage register for inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Ready/valid handshake on both sides.
//   - 2-entry skid buffer, so in_ready is registered and throughput is 1 beat/clock.
//   - Synchronous flush for branch/exception squash.
//   - Replaces hand-instantiated per-bit enable-flop registers with one WIDTH-generic block.
// PARAMETERS
//   WIDTH      32  payload width in bits (>=1)
//   RESET_VAL  0   WIDTH-bit value loaded into main and skid data registers on reset
// PORTS
//   clock      in   1      rising-edge clock
//   clear_n    in   1      asynchronous active-low reset
//   flush      in   1      synchronous squash; empties the stage
//   in_valid   in   1      upstream beat present
//   in_ready   out  1      stage can accept a beat this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      stage holds a beat for downstream
//   out_ready  in   1      downstream accepts this cycle
//   out_data   out  WIDTH  payload of the oldest held beat
//   occupancy  out  2      number of held beats: 0, 1 or 2
// BEHAVIOUR
//   Definitions:
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - out_data is driven from the main register; the skid register holds the second beat.
//   States: EMPTY (occ 0), ONE (main full, occ 1), FULL (main + skid, occ 2).
//   Reset (clear_n low, async):
//   - state=EMPTY; out_valid=0; occupancy=0.
//   - main=skid=RESET_VAL; ready_q=0.
//   - ready_q goes to 1 on the first clock edge after clear_n deasserts.
//   Ready:
//   - in_ready = ready_q & (state!=FULL) & ~flush.
//   - in_ready is 0 throughout reset and for the first edge after reset release.
//   Transitions (flush has top priority):
//   - flush=1: next state EMPTY, whatever push/pop are. No beat is accepted (in_ready=0).
//     A pop asserted in the same cycle is still a legal downstream transfer of the current out_data.
//   - EMPTY: push -> ONE, main<=in_data.
//   - ONE, push & ~pop: -> FULL, skid<=in_data.
//   - ONE, push & pop: stay ONE, main<=in_data.
//   - ONE, ~push & pop: -> EMPTY.
//   - FULL: push impossible. pop -> ONE, main<=skid. No pop -> hold.
//   Data path:
//   - Data registers load only on the writes listed above and hold otherwise.
//   - No data modification and no width conversion.
//   Timing:
//   - Latency in_data -> out_data is 1 clock when the stage is EMPTY or popping.
//   - Sustained push and pop every cycle keeps the stage in ONE with 1 beat/clock throughput.
//   Outputs:
//   - out_valid = (state!=EMPTY).
//   - occupancy encodes state.
//   - All outputs except in_ready are purely registered.
//   Ordering: beats leave in arrival order; none is dropped except by flush, none is duplicated.
//   Stable holding: while out_valid & ~out_ready, out_data and out_valid stay unchanged (except on flush).
//   Reset mid-operation: all held beats are discarded immediately (async); nothing is replayed.
// CONFIGURATION
//   PIPE_STAGE_BUBBLE_ZERO_EN
//   - Defined:
//     - Whenever the next state is EMPTY (pop-to-empty or flush), main<=RESET_VAL and skid<=RESET_VAL.
//     - out_data therefore reads RESET_VAL in every cycle with out_valid=0 (NOP-bubble insertion).
//   - Not defined:
//     - main and skid hold their last loaded values when the stage empties.
//     - out_data is don't-care while out_valid=0.
// TESTING
//   1. Reset then idle: clear_n low 3 clk, release.
//      -> out_valid=0, occupancy=0, out_data=RESET_VAL; in_ready=0 on the release edge, 1 from the next edge on.
//   2. Streaming: in_valid=1 for 8 clk with data 0x10..0x17, out_ready=1.
//      -> out_data 0x10..0x17 on consecutive clocks, 1 clk latency, occupancy stays 1.
//   3. Backpressure: push 0xA, 0xB with out_ready=0.
//      -> occupancy=2, in_ready=0, out_data=0xA held.
//      -> Raise out_ready: 0xA then 0xB pop in order, in_ready returns to 1.
//   4. Flush while FULL (0xA, 0xB held) with in_valid=1 and data 0xC.
//      -> next cycle out_valid=0, occupancy=0; 0xC is not accepted (in_ready=0 during flush).
//   5. Async reset mid-stream with occupancy=2.
//      -> out_valid=0 and occupancy=0 immediately, without a clock edge; main and skid = RESET_VAL.
//   6. PIPE_STAGE_BUBBLE_ZERO_EN defined, RESET_VAL=0x13: pop the last beat 0x55.
//      -> next cycle out_valid=0, out_data=0x13. Undefined build: out_data stays 0x55.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - WIDTH-generic ready/valid pipeline-stage register with 2-entry skid buffer
// Optional feature macro: PIPE_STAGE_BUBBLE_ZERO_EN (reload RESET_VAL whenever the stage empties)
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             ready_q;
  logic             push, pop;
  logic             load_main, load_skid, main_from_skid;
  logic [WIDTH-1:0] main_d;

  // ready_q keeps the stage closed for the first edge after reset release
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign in_ready  = ready_q & (state_q != FULL) & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (push && pop) begin
            load_main = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
      // bubbles carry RESET_VAL so downstream sees a NOP while out_valid is low
      if (state_d == EMPTY) begin
        main_q <= RESET_VAL;
        skid_q <= RESET_VAL;
      end else begin
        if (load_main) main_q <= main_d;
        if (load_skid) skid_q <= in_data;
      end
`else
      if (load_main) main_q <= main_d;
      if (load_skid) skid_q <= in_data;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard testbench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] RVAL = 8'h13;

  logic             clock = 1'b0;
  logic             clear_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] exp_v;

  pipe_stage_reg #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare each downstream transfer, then record each accepted upstream beat
  always @(negedge clock) begin
    if (clear_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got 0x%0h expected no beat at %0t", out_data, $time);
      end else begin
        exp_v = sb.pop_front();
        check("sb_order", {24'h0, out_data}, {24'h0, exp_v});
      end
    end
    if (clear_n && in_valid && in_ready && !flush) sb.push_back(in_data);
  end

  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    tick();
    in_data   = 8'h0B;
    tick();
    in_valid  = 1'b0;
    check("fill_occ", {30'h0, occupancy}, 32'd2);
  endtask

  initial begin
    clear_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // 1. reset then idle
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_occ", {30'h0, occupancy}, 32'd0);
    check("rst_out_data", {24'h0, out_data}, {24'h0, RVAL});
    check("rst_in_ready", {31'h0, in_ready}, 32'd0);
    clear_n = 1'b1;
    #1;
    check("release_in_ready", {31'h0, in_ready}, 32'd0);
    tick();
    check("post_release_in_ready", {31'h0, in_ready}, 32'd1);

    // 2. streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      tick();
      check("stream_data", {24'h0, out_data}, 32'h10 + i);
      check("stream_occ", {30'h0, occupancy}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", {31'h0, out_valid}, 32'd0);

    // 3. backpressure
    fill_ab();
    check("bp_in_ready", {31'h0, in_ready}, 32'd0);
    check("bp_data", {24'h0, out_data}, 32'h0A);
    tick();
    check("bp_hold_data", {24'h0, out_data}, 32'h0A);
    check("bp_hold_valid", {31'h0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_pop1_data", {24'h0, out_data}, 32'h0B);
    check("bp_pop1_ready", {31'h0, in_ready}, 32'd1);
    tick();
    check("bp_pop2_occ", {30'h0, occupancy}, 32'd0);
    out_ready = 1'b0;

    // 4. flush while full
    fill_ab();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h0C;
    #1;
    check("flush_in_ready", {31'h0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_valid", {31'h0, out_valid}, 32'd0);
    check("flush_occ", {30'h0, occupancy}, 32'd0);
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
    check("flush_bubble", {24'h0, out_data}, {24'h0, RVAL});
`else
    check("flush_bubble", {24'h0, out_data}, 32'h0A);
`endif
    tick();
    check("flush_no_accept", {30'h0, occupancy}, 32'd0);

    // 5. async reset mid-stream
    fill_ab();
    #2;
    clear_n = 1'b0;
    #1;
    sb.delete();
    check("arst_valid", {31'h0, out_valid}, 32'd0);
    check("arst_occ", {30'h0, occupancy}, 32'd0);
    check("arst_main", {24'h0, out_data}, {24'h0, RVAL});
    check("arst_skid", {24'h0, dut.skid_q}, {24'h0, RVAL});
    @(posedge clock);
    #1;
    clear_n = 1'b1;
    tick();
    check("arst_ready_back", {31'h0, in_ready}, 32'd1);

    // 6. pop of the last beat
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    check("last_data", {24'h0, out_data}, 32'h55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("last_valid", {31'h0, out_valid}, 32'd0);
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
    check("last_bubble", {24'h0, out_data}, {24'h0, RVAL});
`else
    check("last_bubble", {24'h0, out_data}, 32'h55);
`endif

    tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
